// File: rtl/queen_pkg.sv
// Shared constants and FSM state encoding for the eight-queens search controller.
package queen_pkg;

  localparam int unsigned N_QUEENS = 8;
  localparam int unsigned CYC_W    = 16;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_LOAD_TEST = 4'd2,
    S_CHECK     = 4'd3,
    S_ACCEPT    = 4'd4,
    S_NEXT_ROW  = 4'd5,
    S_BACKTRACK = 4'd6,
    S_RESTORE   = 4'd7,
    S_DONE      = 4'd8,
    S_FAIL      = 4'd9
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/queen_controller.sv
// Backtracking eight-queens search sequencer driving an external counter/stack datapath.
module queen_controller
  import queen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             col_cout,
  input  logic             row_cout,
  input  logic             test_cout,
  input  logic             row_Load_cout,
  input  logic             col_back_cout,
  input  logic             threat,
  output logic             col_en,
  output logic             row_en,
  output logic             test_en,
  output logic             col_rst,
  output logic             row_rst,
  output logic             test_rst,
  output logic             reg_rst,
  output logic             st_rst,
  output logic             row_ld,
  output logic             test_ld,
  output logic             reg_ld,
  output logic             push,
  output logic             pop,
  output logic             UpDown,
  output logic             reg_sel,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CYC_W-1:0] cycles
);

  state_t state, state_nxt;
  logic   cyc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from state and same-cycle status only; start only steers the next state.
  always_comb begin
    state_nxt = state;
    col_en    = 1'b0;
    row_en    = 1'b0;
    test_en   = 1'b0;
    col_rst   = 1'b0;
    row_rst   = 1'b0;
    test_rst  = 1'b0;
    reg_rst   = 1'b0;
    st_rst    = 1'b0;
    row_ld    = 1'b0;
    test_ld   = 1'b0;
    reg_ld    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    UpDown    = 1'b1;
    reg_sel   = 1'b0;
    done      = 1'b0;
    found     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        col_rst   = 1'b1;
        row_rst   = 1'b1;
        test_rst  = 1'b1;
        reg_rst   = 1'b1;
        st_rst    = 1'b1;
        state_nxt = S_LOAD_TEST;
      end
      S_LOAD_TEST: begin
        test_ld   = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Running off the left edge (test wrapped to 7) wins over a stale threat.
        if (test_cout) begin
          state_nxt = S_ACCEPT;
        end else if (threat) begin
          state_nxt = S_NEXT_ROW;
        end else begin
          test_en = 1'b1;
        end
      end
      S_ACCEPT: begin
        reg_ld = 1'b1;
        push   = 1'b1;
        if (col_cout) begin
          state_nxt = S_DONE;
        end else begin
          col_en    = 1'b1;
          row_rst   = 1'b1;
          state_nxt = S_LOAD_TEST;
        end
      end
      S_NEXT_ROW: begin
        if (row_cout) begin
          state_nxt = S_BACKTRACK;
        end else begin
          row_en    = 1'b1;
          state_nxt = S_LOAD_TEST;
        end
      end
      S_BACKTRACK: begin
        if (col_back_cout) begin
          state_nxt = S_FAIL;
        end else begin
          col_en    = 1'b1;
          UpDown    = 1'b0;
          state_nxt = S_RESTORE;
        end
      end
      S_RESTORE: begin
        pop = 1'b1;
        if (row_Load_cout) begin
          state_nxt = S_BACKTRACK;
        end else begin
          row_ld    = 1'b1;
          state_nxt = S_LOAD_TEST;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        found   = 1'b1;
        reg_sel = 1'b1;
        if (start) state_nxt = S_INIT;
      end
      S_FAIL: begin
        done = 1'b1;
        if (start) state_nxt = S_INIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);
  assign cyc_clr = (state == S_INIT);

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cyc_clr),
    .en    (busy),
    .q     (cycles)
  );

endmodule
